// File: rtl/acc_pkg.sv
// Shared sizes and the result FIFO entry layout for the accumulator datapath.
package acc_pkg;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 11;
  localparam int GROUPS     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int GIDX_W     = $clog2(GROUPS);
  localparam int ENTRY_W    = ACC_W + 1;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             last;
  } res_entry_t;
endpackage

// File: rtl/acc_datapath_if.sv
// Strobe, memory and result-stream bundle between the control FSM, the
// accumulator datapath and the downstream consumer.
interface acc_datapath_if;
  import acc_pkg::*;

  logic [DATA_W-1:0] read_data;
  logic              load;
  logic              clear_n;
  logic              transfer;
  logic              write_en;
  logic              ready;
  logic [ACC_W-1:0]  write_data;
  logic [ACC_W-1:0]  result_data;
  logic              result_last;
  logic              result_valid;
  logic              result_ready;
  logic              overflow;
  logic              dropped;
  logic              seq_error;

  modport master (
    output read_data, load, clear_n, transfer, write_en, ready, result_ready,
    input  write_data, result_data, result_last, result_valid,
           overflow, dropped, seq_error
  );

  modport slave (
    input  read_data, load, clear_n, transfer, write_en, ready, result_ready,
    output write_data, result_data, result_last, result_valid,
           overflow, dropped, seq_error
  );
endinterface

// File: rtl/result_fifo.sv
// Synchronous result FIFO: simultaneous push/pop, drop-on-full status pulse.
module result_fifo
  import acc_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  res_entry_t i_data,
  input  logic       i_pop,
  output res_entry_t o_head,
  output logic       o_valid,
  output logic       o_full,
  output logic       o_drop
);
  localparam int PTR_W = $clog2(DEPTH);

  res_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_pop;
  logic w_push;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_pop   = i_pop && o_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_drop  = i_push && !w_push;
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath: operand/acc registers, group indexing, sticky status,
// and the group-sum result FIFO. Define ACC_SATURATE_EN to saturate on carry.
module acc_datapath
  import acc_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst_n,
  acc_datapath_if.slave  bus
);
  localparam int SUM_W = ACC_W + 1;

  logic [DATA_W-1:0] r_operand;
  logic [ACC_W-1:0]  r_acc;
  logic [GIDX_W-1:0] r_gidx;
  logic              r_overflow;
  logic              r_dropped;
  logic              r_seq_err;

  logic [SUM_W-1:0]  w_sum;
  logic              w_carry;
  logic [ACC_W-1:0]  w_acc_add;
  logic              w_last_grp;
  res_entry_t        w_entry;
  res_entry_t        w_head;
  logic              w_valid;
  logic              w_full;
  logic              w_drop;

  assign w_sum   = {1'b0, r_acc} + SUM_W'(r_operand);
  assign w_carry = w_sum[ACC_W];

`ifdef ACC_SATURATE_EN
  assign w_acc_add = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  assign w_last_grp   = (r_gidx == GIDX_W'(GROUPS-1));
  // Push sees the pre-clear accumulator even if Clear lands in the same cycle.
  assign w_entry.sum  = r_acc;
  assign w_entry.last = w_last_grp;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_operand  <= '0;
      r_acc      <= '0;
      r_gidx     <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if (bus.load) r_operand <= bus.read_data;

      if (!bus.clear_n) begin
        r_acc <= '0;
      end else if (bus.transfer) begin
        r_acc <= w_acc_add;
        if (w_carry) r_overflow <= 1'b1;
      end

      if (w_drop) r_dropped <= 1'b1;

      // End-of-run with a partial group resyncs the index rather than counting on.
      if (bus.ready && r_gidx != '0) begin
        r_seq_err <= 1'b1;
        r_gidx    <= '0;
      end else if (bus.write_en) begin
        r_gidx <= w_last_grp ? '0 : r_gidx + 1'b1;
      end
    end
  end

  result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (bus.write_en),
    .i_data  (w_entry),
    .i_pop   (bus.result_ready),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign bus.write_data   = r_acc;
  assign bus.result_data  = w_head.sum;
  assign bus.result_last  = w_head.last;
  assign bus.result_valid = w_valid;
  assign bus.overflow     = r_overflow;
  assign bus.dropped      = r_dropped;
  assign bus.seq_error    = r_seq_err;
endmodule

// File: tb/tb_acc_datapath.sv
// Scoreboard bench for acc_datapath: expected group sums queued at push time,
// compared against the FIFO head when the consumer pops.
module tb_acc_datapath;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_datapath_if bus ();

  acc_datapath dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct { int sum; int last; } ent_t;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t q[$];
  int   pop_sum[$];
  int   pop_last[$];
  int   m_op, m_acc, m_idx;
  int   m_ovf, m_drop, m_seq;

  localparam int ACC_MAX = (1 << ACC_W) - 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_acc = 0; m_idx = 0;
    m_ovf = 0; m_drop = 0; m_seq = 0;
    q.delete();
    pop_sum.delete();
    pop_last.delete();
  endtask

  // Observe/model at the falling edge, then let the rising edge commit.
  task automatic tick();
    int s;
    ent_t e;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      chk("valid", int'(bus.result_valid), int'(q.size() != 0));
      if (bus.result_ready && q.size() != 0) begin
        chk("head_sum", int'(bus.result_data), q[0].sum);
        chk("head_last", int'(bus.result_last), q[0].last);
        pop_sum.push_back(int'(bus.result_data));
        pop_last.push_back(int'(bus.result_last));
        void'(q.pop_front());
      end
      if (bus.write_en) begin
        e.sum  = m_acc;
        e.last = (m_idx == GROUPS-1) ? 1 : 0;
        if (q.size() < FIFO_DEPTH) q.push_back(e);
        else m_drop = 1;
      end
      if (bus.ready && m_idx != 0) begin
        m_seq = 1; m_idx = 0;
      end else if (bus.write_en) begin
        m_idx = (m_idx + 1) % GROUPS;
      end
      if (!bus.clear_n) begin
        m_acc = 0;
      end else if (bus.transfer) begin
        s = m_acc + m_op;
        if (s > ACC_MAX) begin
          m_ovf = 1;
`ifdef ACC_SATURATE_EN
          s = ACC_MAX;
`else
          s = s - (ACC_MAX + 1);
`endif
        end
        m_acc = s;
      end
      if (bus.load) m_op = int'(bus.read_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read_data = '0; bus.load = 0; bus.clear_n = 1;
    bus.transfer = 0; bus.write_en = 0; bus.ready = 0;
  endtask

  task automatic word(input int d);
    bus.read_data = DATA_W'(d); bus.load = 1;
    tick();
    bus.load = 0; bus.transfer = 1;
    tick();
    bus.transfer = 0;
  endtask

  task automatic push_clr();
    bus.write_en = 1; bus.clear_n = 0;
    tick();
    bus.write_en = 0; bus.clear_n = 1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  // Full FSM run: four groups of eight words, each pushed with a same-cycle clear.
  task automatic run(input int first);
    bus.clear_n = 0; tick(); bus.clear_n = 1;
    for (int g = 0; g < GROUPS; g++) begin
      for (int w = 0; w < 8; w++) word(first + g*8 + w);
      push_clr();
    end
    bus.ready = 1; tick(); bus.ready = 0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ovf"},  int'(bus.overflow),  m_ovf);
    chk({tag, "_drop"}, int'(bus.dropped),   m_drop);
    chk({tag, "_seq"},  int'(bus.seq_error), m_seq);
    chk({tag, "_wd"},   int'(bus.write_data), m_acc);
  endtask

  initial begin
    idle();
    bus.result_ready = 0;
    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
    chk("rst_wd", int'(bus.write_data), 0);
    chk("rst_valid", int'(bus.result_valid), 0);
    chk("rst_data", int'(bus.result_data), 0);
    chk("rst_last", int'(bus.result_last), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_drop", int'(bus.dropped), 0);
    chk("rst_seq", int'(bus.seq_error), 0);

    // Streaming run, consumer always ready.
    bus.result_ready = 1;
    run(1);
    tick(); tick();
    chk("run_pops", pop_sum.size(), 4);
    if (pop_sum.size() == 4) begin
      chk("run_s0", pop_sum[0], 36);
      chk("run_s1", pop_sum[1], 100);
      chk("run_s2", pop_sum[2], 164);
      chk("run_s3", pop_sum[3], 228);
      chk("run_l2", pop_last[2], 0);
      chk("run_l3", pop_last[3], 1);
    end
    chk("run_seq", int'(bus.seq_error), 0);
    chk_flags("run");

    // Consumer stalled: four entries held, a fifth push is dropped.
    do_reset();
    bus.result_ready = 0;
    run(1);
    chk("hold_valid", int'(bus.result_valid), 1);
    chk("hold_drop", int'(bus.dropped), 0);
    chk("hold_head", int'(bus.result_data), 36);
    bus.write_en = 1; tick(); bus.write_en = 0;
    chk("xtra_drop", int'(bus.dropped), 1);
    chk("xtra_head", int'(bus.result_data), 36);
    chk("xtra_q", q.size(), 4);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    run(1);
    word(5);
    chk("acc5", int'(bus.write_data), 5);
    bus.write_en = 1; bus.result_ready = 1;
    tick();
    bus.write_en = 0; bus.result_ready = 0;
    chk("pp_drop", int'(bus.dropped), 0);
    chk("pp_head", int'(bus.result_data), 100);
    chk("pp_q", q.size(), 4);
    bus.result_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("pp_pops", pop_sum.size(), 5);
    if (pop_sum.size() == 5) begin
      chk("pp_first", pop_sum[0], 36);
      chk("pp_new", pop_sum[4], 5);
      chk("pp_newl", pop_last[4], 0);
    end

    // Carry out of the accumulator.
    do_reset();
    bus.clear_n = 0; tick(); bus.clear_n = 1;
    for (int i = 0; i < 9; i++) word(8'hFF);
`ifdef ACC_SATURATE_EN
    chk("ovf_acc", int'(bus.write_data), 2047);
`else
    chk("ovf_acc", int'(bus.write_data), 247);
`endif
    chk("ovf_flag", int'(bus.overflow), 1);
    chk_flags("ovf");

    // Early end-of-run after two pushes.
    do_reset();
    bus.clear_n = 0; tick(); bus.clear_n = 1;
    word(3); push_clr();
    word(4); push_clr();
    bus.ready = 1; tick(); bus.ready = 0;
    chk("seq_flag", int'(bus.seq_error), 1);
    for (int g = 0; g < GROUPS; g++) begin
      word(10 + g); push_clr();
    end
    tick(); tick();
    chk("seq_pops", pop_sum.size(), 6);
    if (pop_sum.size() == 6) begin
      chk("seq_nxt_last", pop_last[2], 0);
      chk("seq_nxt_sum", pop_sum[2], 10);
      chk("seq_l3", pop_last[4], 0);
      chk("seq_l4", pop_last[5], 1);
    end
    chk_flags("seq");

    // Reset in the middle of a group with entries pending.
    do_reset();
    bus.result_ready = 0;
    bus.clear_n = 0; tick(); bus.clear_n = 1;
    word(3); push_clr();
    word(4); push_clr();
    bus.ready = 1; tick(); bus.ready = 0;
    word(20);
    chk("mid_acc", int'(bus.write_data), 20);
    chk("mid_valid", int'(bus.result_valid), 1);
    chk("mid_seq", int'(bus.seq_error), 1);
    do_reset();
    chk("mrst_acc", int'(bus.write_data), 0);
    chk("mrst_valid", int'(bus.result_valid), 0);
    chk("mrst_seq", int'(bus.seq_error), 0);
    chk("mrst_ovf", int'(bus.overflow), 0);
    chk("mrst_drop", int'(bus.dropped), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
